// File: rtl/vector_multiplication_writeback_pkg.sv
// Shared types and constants for the vector multiplication writeback stage.
// The held payload and FSM state encodings live here so checkers can bind to them.
package vector_multiplication_writeback_pkg;

  localparam int DATA_WIDTH            = 64;
  localparam int REG_ADDR_WIDTH        = 5;
  localparam int STROBE_WIDTH          = DATA_WIDTH / 8;
  localparam int VECTOR_REGISTER_COUNT = 32;

  localparam logic [1:0] DISABLED_WIDENING_MODE = 2'b00;
  localparam logic [1:0] ENABLED_WIDENING_MODE  = 2'b01;

  typedef struct packed {
    logic [1:0] widening_mode;
  } execution_vector_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_LOW  = 2'd1,
    WRITE_HIGH = 2'd2
  } writeback_state_t;

  // Only what the second beat still needs; the first beat lives in the wr_* registers.
  typedef struct packed {
    logic                  widening;
    logic [DATA_WIDTH-1:0] vd_high;
  } writeback_payload_t;

  function automatic logic [REG_ADDR_WIDTH-1:0] next_register(input logic [REG_ADDR_WIDTH-1:0] idx);
    return idx + REG_ADDR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/vector_multiplication_writeback_if.sv
// Register-file write port: valid/ready; a beat transfers on a cycle where wr_valid && wr_ready,
// and while wr_valid is high without wr_ready the address, data and strobe hold stable.
interface vector_multiplication_writeback_if
  import vector_multiplication_writeback_pkg::*;
();
  logic                      wr_valid;
  logic                      wr_ready;
  logic [REG_ADDR_WIDTH-1:0] wr_address;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic [STROBE_WIDTH-1:0]   wr_strobe;

  modport master (output wr_valid, output wr_address, output wr_data, output wr_strobe,
                  input  wr_ready);
  modport slave  (input  wr_valid, input  wr_address, input  wr_data, input  wr_strobe,
                  output wr_ready);
endinterface

// File: rtl/vector_multiplication_writeback.sv
// Registers a multiplier result and writes it to the vector register file in one
// (non-widening) or two (widening) 64-bit beats; misaligned widening results are dropped.
module vector_multiplication_writeback
  import vector_multiplication_writeback_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  execution_vector_t                 execution_vector,
  input  logic [REG_ADDR_WIDTH-1:0]         vd_index,
  input  logic [DATA_WIDTH-1:0]             vd,
  input  logic [DATA_WIDTH-1:0]             vd_high,
  input  logic [STROBE_WIDTH-1:0]           byte_mask,
  vector_multiplication_writeback_if.master wr,
  output logic                              retire,
  output logic                              misaligned_error,
  output writeback_state_t                  dbg_state
);

  writeback_state_t          state_q, state_d;
  writeback_payload_t        payload_q, payload_d;
  logic [REG_ADDR_WIDTH-1:0] wr_address_q, wr_address_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic [STROBE_WIDTH-1:0]   wr_strobe_q, wr_strobe_d;
  logic                      retire_q, retire_d;
  logic                      misaligned_q, misaligned_d;

  logic widening_in;
  logic final_beat;
  logic accept;
  logic load_new;

  always_comb begin
    widening_in = (execution_vector.widening_mode == ENABLED_WIDENING_MODE);
    final_beat  = (state_q == WRITE_HIGH) || ((state_q == WRITE_LOW) && !payload_q.widening);
    in_ready    = (state_q == IDLE) || (final_beat && wr.wr_ready);
    accept      = in_valid && in_ready;
    // An odd destination cannot host a register pair, so such a result is consumed without a beat.
    load_new    = accept && !(widening_in && vd_index[0]);
  end

  always_comb begin
    state_d      = state_q;
    payload_d    = payload_q;
    wr_address_d = wr_address_q;
    wr_data_d    = wr_data_q;
    wr_strobe_d  = wr_strobe_q;
    retire_d     = 1'b0;
    misaligned_d = accept && widening_in && vd_index[0];

    if ((state_q == WRITE_LOW) && wr.wr_ready && payload_q.widening) begin
      state_d      = WRITE_HIGH;
      wr_address_d = next_register(wr_address_q);
      wr_data_d    = payload_q.vd_high;
    end else if (final_beat && wr.wr_ready) begin
      retire_d = 1'b1;
      state_d  = IDLE;
    end

    if (load_new) begin
      state_d            = WRITE_LOW;
      payload_d.widening = widening_in;
      payload_d.vd_high  = vd_high;
      wr_address_d       = vd_index;
      wr_data_d          = vd;
      wr_strobe_d        = byte_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      payload_q    <= '0;
      wr_address_q <= '0;
      wr_data_q    <= '0;
      wr_strobe_q  <= '0;
      retire_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      payload_q    <= payload_d;
      wr_address_q <= wr_address_d;
      wr_data_q    <= wr_data_d;
      wr_strobe_q  <= wr_strobe_d;
      retire_q     <= retire_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Every non-IDLE state is presenting a beat, so wr_valid is a pure decode of the state flops.
  assign wr.wr_valid       = (state_q != IDLE);
  assign wr.wr_address     = wr_address_q;
  assign wr.wr_data        = wr_data_q;
  assign wr.wr_strobe      = wr_strobe_q;
  assign retire            = retire_q;
  assign misaligned_error  = misaligned_q;
  assign dbg_state         = state_q;

endmodule
